// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - MAC control interface op codes, shared with the control FSM
package mac_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_NOP = 2'b00;
  localparam op_t OP_MUL = 2'b01;
  localparam op_t OP_MAC = 2'b10;
  localparam op_t OP_CLR = 2'b11;

endpackage

// File: rtl/mac_mul_stage.sv
// rtl/mac_mul_stage.sv - stage-1 register: op code, zero-extended product and valid
module mac_mul_stage
  import mac_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic [1:0]    in_op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          s1_valid,
  output logic [1:0]    s1_op,
  output logic [AW-1:0] s1_prod
);

  logic [2*DW-1:0] prod_full;

  assign prod_full = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

  // A deasserted in_valid while enabled loads a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_NOP;
      s1_prod  <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_op    <= in_op;
      s1_prod  <= AW'(prod_full);
    end
  end

endmodule

// File: rtl/mac_datapath.sv
// rtl/mac_datapath.sv - 2-stage multiply/accumulate responder with saturating accumulator
module mac_datapath
  import mac_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ctrl_valid,
  input  logic [1:0]    ctrl,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic          ctrl_ready,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [AW-1:0] res_data,
  output logic          ovf,
  output logic          busy
);

  logic          stall;
  logic          s1_valid;
  logic [1:0]    s1_op;
  logic [AW-1:0] s1_prod;
  logic          s2_fire;
  logic [AW:0]   sum;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;
  logic          ovf_next;
  logic          produce;

  assign stall      = res_valid & ~res_ready;
  assign ctrl_ready = ~stall;
  assign busy       = s1_valid | res_valid;
  assign s2_fire    = s1_valid & ~stall;

  mac_mul_stage #(.DW(DW), .AW(AW)) u_mul_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (~stall),
    .in_valid (ctrl_valid),
    .in_op    (ctrl),
    .a        (op_a),
    .b        (op_b),
    .s1_valid (s1_valid),
    .s1_op    (s1_op),
    .s1_prod  (s1_prod)
  );

  // One extra bit on the sum exposes the carry used for saturation.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, s1_prod};
    acc_next = acc;
    ovf_next = ovf;
    produce  = 1'b0;
    case (op_t'(s1_op))
      OP_MUL: begin
        acc_next = s1_prod;
        ovf_next = 1'b0;
        produce  = 1'b1;
      end
      OP_MAC: begin
        produce = 1'b1;
        if (sum[AW]) begin
          acc_next = '1;
          ovf_next = 1'b1;
        end else begin
          acc_next = sum[AW-1:0];
        end
      end
      OP_CLR: begin
        acc_next = '0;
        ovf_next = 1'b0;
        produce  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      if (s2_fire) begin
        acc <= acc_next;
        ovf <= ovf_next;
      end
      if (s2_fire && produce) begin
        res_data  <= acc_next;
        res_valid <= 1'b1;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_datapath.sv
// tb/tb_mac_datapath.sv - randomized and directed self-checking bench for mac_datapath
module tb_mac_datapath;
  import mac_pkg::*;

  localparam int DW = 8;
  localparam int AW = 16;
  localparam longint ACC_MAX = (64'd1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ctrl_valid;
  logic [1:0]    ctrl;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic          ctrl_ready;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_data;
  logic          ovf;
  logic          busy;

  mac_datapath #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrl_valid (ctrl_valid),
    .ctrl       (ctrl),
    .op_a       (op_a),
    .op_b       (op_b),
    .ctrl_ready (ctrl_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .ovf        (ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    bit     ovf;
  } res_t;

  res_t   exp_q[$];
  longint m_acc;
  bit     m_ovf;
  int     n_checks = 0;
  int     n_fail   = 0;
  bit     seen_valid;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Results are computed at accept time, in accept order: the spec's in-order accumulate.
  function automatic void model_apply(input logic [1:0] op, input int a, input int b);
    longint prod = longint'(a) * longint'(b);
    res_t r;
    case (op)
      OP_MUL: begin m_acc = prod; m_ovf = 1'b0; end
      OP_MAC: begin
        if (m_acc + prod > ACC_MAX) begin m_acc = ACC_MAX; m_ovf = 1'b1; end
        else m_acc = m_acc + prod;
      end
      OP_CLR: begin m_acc = 0; m_ovf = 1'b0; end
      default: return;
    endcase
    r.data = m_acc;
    r.ovf  = m_ovf;
    exp_q.push_back(r);
  endfunction

  task automatic step(input bit cv, input logic [1:0] op, input int a, input int b,
                      input bit rr, output bit accepted);
    @(negedge clk);
    ctrl_valid = cv;
    ctrl       = op;
    op_a       = a[DW-1:0];
    op_b       = b[DW-1:0];
    res_ready  = rr;
    #1;
    seen_valid = res_valid;
    check("ctrl_ready_rule", ctrl_ready, !(res_valid && !rr));
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", res_valid, 0);
      end else begin
        check("res_data", res_data, exp_q[0].data);
        check("ovf", ovf, exp_q[0].ovf);
        if (rr) void'(exp_q.pop_front());
      end
    end
    accepted = cv && ctrl_ready;
    if (accepted) model_apply(op, a, b);
  endtask

  task automatic issue(input logic [1:0] op, input int a, input int b, input bit rr);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 50) begin
      step(1'b1, op, a, b, rr, acc);
      n++;
    end
    if (!acc) check("issue_timeout", acc, 1);
  endtask

  task automatic idle(input int n, input bit rr);
    bit acc;
    repeat (n) step(1'b0, OP_NOP, 0, 0, rr, acc);
  endtask

  task automatic drain();
    idle(6, 1'b1);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ctrl_valid = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_q.delete();
    m_acc = 0;
    m_ovf = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    rst_n = 1'b0; ctrl_valid = 1'b0; ctrl = OP_NOP; op_a = '0; op_b = '0; res_ready = 1'b1;
    do_reset();
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_res_data", res_data, 0);
    check("rst_ctrl_ready", ctrl_ready, 1);

    // Latency: result visible after exactly two edges.
    issue(OP_MUL, 3, 4, 1'b1);
    idle(1, 1'b1); check("lat_edge1", seen_valid, 0);
    idle(1, 1'b1); check("lat_edge2", seen_valid, 1);
    drain();

    // Back-to-back: 12, 42, 46 on consecutive cycles.
    issue(OP_MUL, 3, 4, 1'b1);
    issue(OP_MAC, 5, 6, 1'b1);
    issue(OP_MAC, 2, 2, 1'b1); check("b2b_r0", seen_valid, 1);
    idle(1, 1'b1); check("b2b_r1", seen_valid, 1);
    idle(1, 1'b1); check("b2b_r2", seen_valid, 1);
    idle(1, 1'b1); check("b2b_end", seen_valid, 0);
    drain();

    // Saturation then CLR.
    issue(OP_MUL, 255, 255, 1'b1);
    issue(OP_MAC, 255, 255, 1'b1);
    idle(2, 1'b1);
    check("sat_ovf_sticky", ovf, 1);
    issue(OP_CLR, 0, 0, 1'b1);
    drain();
    check("clr_ovf", ovf, 0);

    // Backpressure: hold res_ready low across three ops.
    issue(OP_MUL, 1, 2, 1'b0);
    issue(OP_MAC, 1, 1, 1'b0);
    step(1'b1, OP_MAC, 1, 1, 1'b0, acc);
    check("bp_ready_low", ctrl_ready, 0);
    check("bp_not_accepted", acc, 0);
    repeat (3) step(1'b1, OP_MAC, 1, 1, 1'b0, acc);
    check("bp_hold_data", res_data, 2);
    issue(OP_MAC, 1, 1, 1'b1);
    drain();

    // NOPs and bubbles between MACs produce nothing.
    issue(OP_CLR, 0, 0, 1'b1);
    issue(OP_MAC, 2, 3, 1'b1);
    issue(OP_NOP, 9, 9, 1'b1);
    idle(2, 1'b1);
    issue(OP_NOP, 7, 7, 1'b1);
    issue(OP_MAC, 1, 1, 1'b1);
    drain();
    check("nop_final_data", res_data, 7);

    // Reset with ops in both stages.
    issue(OP_MUL, 7, 7, 1'b1);
    issue(OP_MAC, 1, 1, 1'b1);
    do_reset();
    check("midrst_res_valid", res_valid, 0);
    check("midrst_busy", busy, 0);
    issue(OP_MAC, 2, 2, 1'b1);
    drain();
    check("midrst_acc_zero", res_data, 4);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(99) < 75, 2'($urandom_range(3)),
           int'($urandom_range(255)), int'($urandom_range(255)),
           $urandom_range(99) < 70, acc);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
